hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage 16-bit core (IF, ID, EX, MEM, WB).
- Tracks destination registers of in-flight instructions in a private shadow pipeline.
- Generates load-use stalls, control-flow flushes, PC redirect select and registered EX-stage forwarding selects.
- Keeps saturating stall/flush event counters for debug readout.
- Sits beside the decode-stage controller and consumes its decoded control bits.

---
 rtl/hazard_ctrl_pkg.sv | 29 ++
 rtl/hazard_ctrl_sat_counter.sv | 13 +
 rtl/hazard_ctrl.sv | 71 +++++++
 tb/tb_hazard_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared encodings, opcodes and shadow-slot type for the hazard controller.
package hazard_ctrl_pkg;
  localparam int SLOT_AW = 3;
  localparam logic [SLOT_AW-1:0] REG_ZERO = '0;
  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_JMP = 2'b01;
  localparam logic [1:0] PCSEL_BR  = 2'b10;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_BEQ   = 4'h6;
  localparam logic [3:0] OP_BNE   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_CALL  = 4'h9;
  localparam logic [3:0] OP_RET   = 4'hA;
  localparam logic [3:0] OP_FOR   = 4'hB;
  typedef struct packed {
    logic               valid;
    logic               we;
    logic               load;
    logic [SLOT_AW-1:0] rd;
  } slot_t;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stalls, redirect flushes, PC select and registered EX forwarding selects.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = SLOT_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_write_reg,
  input  logic              id_load,
  input  logic              id_jump,
  input  logic              ex_redirect,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [1:0]        pc_sel,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  // The WB slot never drives an output (regfile writes first half-cycle), so only EX and MEM are kept.
  slot_t s_ex, s_mem, entry;
  logic stall, jump, hit_ex1, hit_ex2, hit_mem1, hit_mem2;
  logic [1:0] nfa, nfb;
  function automatic logic hit(slot_t s, logic [REG_AW-1:0] r);
    return s.valid & s.we & (s.rd == r) & (r != REG_ZERO);
  endfunction
  always_comb begin
    hit_ex1  = hit(s_ex, id_rs1) & id_use_rs1;
    hit_ex2  = hit(s_ex, id_rs2) & id_use_rs2;
    hit_mem1 = hit(s_mem, id_rs1) & id_use_rs1;
    hit_mem2 = hit(s_mem, id_rs2) & id_use_rs2;
    stall    = id_valid & s_ex.load & (hit_ex1 | hit_ex2);
    jump     = id_jump & id_valid & ~stall & ~ex_redirect;
    pc_write_en    = ex_redirect | ~stall;
    if_id_write_en = ex_redirect | ~stall;
    if_id_flush    = ex_redirect | jump;
    id_ex_flush    = ex_redirect | stall;
    pc_sel = ex_redirect ? PCSEL_BR : jump ? PCSEL_JMP : PCSEL_SEQ;
    nfa = hit_ex1 ? FWD_EXMEM : hit_mem1 ? FWD_MEMWB : FWD_RF;
    nfb = hit_ex2 ? FWD_EXMEM : hit_mem2 ? FWD_MEMWB : FWD_RF;
    entry = '{valid: id_valid, we: id_write_reg & (id_rd != REG_ZERO), load: id_load, rd: id_rd};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_ex  <= '0;
      s_mem <= '0;
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else begin
      s_mem <= s_ex;
      s_ex  <= id_ex_flush ? '0 : entry;
      fwd_a <= id_ex_flush ? FWD_RF : nfa;
      fwd_b <= id_ex_flush ? FWD_RF : nfb;
    end
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(stall & ~ex_redirect), .cnt(stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(ex_redirect | jump), .cnt(flush_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: random and directed stimulus checked every cycle against an instruction-history model.
module tb_hazard_ctrl;
  localparam int CW = 10;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid, id_use_rs1, id_use_rs2, id_write_reg, id_load, id_jump, ex_redirect;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic pc_write_en, if_id_write_en, if_id_flush, id_ex_flush;
  logic [1:0] pc_sel, fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;
  hazard_ctrl #(.REG_AW(3), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_write_reg(id_write_reg),
    .id_load(id_load), .id_jump(id_jump), .ex_redirect(ex_redirect), .pc_write_en(pc_write_en),
    .if_id_write_en(if_id_write_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pc_sel(pc_sel), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {bit v; bit w; bit ld; int rd;} ins_t;
  ins_t hist[$];
  int m_stall, m_flush, m_fa, m_fb;
  int vectors = 0, miscompares = 0;
  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    ins_t b = '{0, 0, 0, 0};
    hist = {};
    hist.push_back(b);
    hist.push_back(b);
    m_stall = 0; m_flush = 0; m_fa = 0; m_fb = 0;
  endtask
  // Distance (1 = instruction now in EX, 2 = now in MEM) of the nearest writer of r, 0 if none.
  function automatic int src(int r, bit u);
    if (!u || r == 0) return 0;
    for (int d = 1; d <= 2; d++) begin
      ins_t p;
      p = hist[hist.size() - d];
      if (p.v && p.w && p.rd == r) return d;
    end
    return 0;
  endfunction
  function automatic bit m_stall_now();
    return id_valid && hist[hist.size() - 1].ld &&
           (src(id_rs1, id_use_rs1) == 1 || src(id_rs2, id_use_rs2) == 1);
  endfunction
  task automatic compare();
    bit st, jmp;
    st = m_stall_now();
    jmp = id_valid && id_jump;
    chk("pc_write_en", pc_write_en, ex_redirect || !st);
    chk("if_id_write_en", if_id_write_en, ex_redirect || !st);
    chk("if_id_flush", if_id_flush, ex_redirect || (!st && jmp));
    chk("id_ex_flush", id_ex_flush, ex_redirect || st);
    chk("pc_sel", pc_sel, ex_redirect ? 2 : st ? 0 : jmp ? 1 : 0);
    chk("fwd_a", fwd_a, m_fa);
    chk("fwd_b", fwd_b, m_fb);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
  endtask
  task automatic drive(bit v, int r1, int r2, bit u1, bit u2, int rd, bit we, bit ld, bit j, bit br);
    @(negedge clk);
    id_valid = v; id_rs1 = 3'(r1); id_rs2 = 3'(r2); id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = 3'(rd); id_write_reg = we; id_load = ld; id_jump = j; ex_redirect = br;
    #1 compare();
  endtask
  task automatic step();
    bit st, bub, jmp;
    int na, nb;
    ins_t n;
    st = m_stall_now();
    jmp = id_valid && id_jump;
    bub = ex_redirect || st;
    na = bub ? 0 : src(id_rs1, id_use_rs1);
    nb = bub ? 0 : src(id_rs2, id_use_rs2);
    n = bub ? '{0, 0, 0, 0} : '{id_valid, id_write_reg, id_load, int'(id_rd)};
    if (!ex_redirect && st && m_stall < CMAX) m_stall++;
    if ((ex_redirect || (jmp && !st)) && m_flush < CMAX) m_flush++;
    @(posedge clk);
    hist.push_back(n);
    if (hist.size() > 3) void'(hist.pop_front());
    m_fa = na;
    m_fb = nb;
  endtask
  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask
  task automatic rnd(int maxreg);
    drive($urandom_range(0, 99) < 85, $urandom_range(0, maxreg), $urandom_range(0, maxreg),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, maxreg),
          $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35,
          $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10);
    step();
  endtask
  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pc_write_en", pc_write_en, 1);
    chk("rst_fwd_a", fwd_a, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) nop();
    // ADD r1 ; ADD r2,r1,r3 back-to-back
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); step();
    drive(1, 1, 3, 1, 1, 2, 1, 0, 0, 0);
    chk("b2b_no_stall", pc_write_en, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("b2b_fwd_a", fwd_a, 1);
    chk("b2b_fwd_b", fwd_b, 0);
    step();
    // ADD r1 ; NOP ; ADD r2,r1,r3
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); step();
    nop();
    drive(1, 1, 3, 1, 1, 2, 1, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("gap_fwd_a", fwd_a, 2);
    step();
    // LOAD r4 ; ADD r5,r4,r4
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); step();
    drive(1, 4, 4, 1, 1, 5, 1, 0, 0, 0);
    chk("lu_pc_write_en", pc_write_en, 0);
    chk("lu_id_ex_flush", id_ex_flush, 1);
    step();
    drive(1, 4, 4, 1, 1, 5, 1, 0, 0, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_released", pc_write_en, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_fwd_a", fwd_a, 2);
    chk("lu_fwd_b", fwd_b, 2);
    step();
    // branch redirect overrides a load-use stall
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); step();
    drive(1, 4, 0, 1, 0, 5, 1, 0, 0, 1);
    chk("br_pc_sel", pc_sel, 2);
    chk("br_if_id_flush", if_id_flush, 1);
    chk("br_id_ex_flush", id_ex_flush, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("br_stall_cnt", stall_cnt, 1);
    chk("br_flush_cnt", flush_cnt, 1);
    step();
    // CALL stalled by a preceding LOAD
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 0); step();
    drive(1, 6, 0, 1, 0, 7, 1, 0, 1, 0);
    chk("call_stall_pc_sel", pc_sel, 0);
    chk("call_stall_pc_write_en", pc_write_en, 0);
    step();
    drive(1, 6, 0, 1, 0, 7, 1, 0, 1, 0);
    chk("call_pc_sel", pc_sel, 1);
    chk("call_if_id_flush", if_id_flush, 1);
    step();
    // R0 producers never stall or forward
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); step();
    drive(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    chk("r0_no_stall", pc_write_en, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_fwd_a", fwd_a, 0);
    step();
    repeat (60) rnd(0);
    repeat (2000) rnd(3);
    // self-dependent load repeats, stalling every other cycle until saturation
    for (int i = 0; i < 3000 && m_stall < CMAX; i++) begin
      drive(1, 4, 0, 1, 0, 4, 1, 1, 0, 0); step();
    end
    repeat (6) begin drive(1, 4, 0, 1, 0, 4, 1, 1, 0, 0); step(); end
    drive(1, 4, 0, 1, 0, 4, 1, 1, 0, 0);
    chk("sat_stall_cnt", stall_cnt, CMAX);
    if (!m_stall_now()) begin step(); drive(1, 4, 0, 1, 0, 4, 1, 1, 0, 0); end
    chk("pre_rst_stalled", pc_write_en, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_stall_drop", pc_write_en, 1);
    chk("rst_id_ex_flush", id_ex_flush, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_fwd_b", fwd_b, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) rnd(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
